accumulator_control: RTL
========================

Name: accumulator_control

Overview:
- Multicycle control unit for the 16-bit accumulator datapath (accumulatorFull).
- Sequences fetch/decode/execute and generates every write enable and mux select for PC, IR, ACC, memory and the IO ports.
- Sits beside the datapath. It receives the IR opcode field and ACC status flags, and drives the datapath control bus.
- Enables programs such as the GCD routine to run from reset without external sequencing.

Parameters:
- OPW, 4, opcode field width taken from IR[15:12].
- STW, 3, state register width.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  OPW  IR[15:12] from the datapath instruction register.
- acc_zero  input  1  ACC == 0 (combinational from the ACC register).
- acc_neg  input  1  ACC[15].
- pc_write  output  1  PC load enable.
- pc_src  output  2  00 = PC+1, 01 = IR[11:0] jump target, others reserved.
- ir_write  output  1  IR load enable from instruction memory.
- acc_write  output  1  ACC load enable.
- acc_src  output  2  00 = ALU result, 01 = IR immediate (sign-extended), 10 = memory data, 11 = IOIn.
- alu_op  output  2  00 = pass B, 01 = ACC+B, 10 = ACC-B.
- alu_b_src  output  1  0 = memory data register, 1 = sign-extended immediate.
- mem_write  output  1  data memory write enable (writes ACC).
- out_write  output  1  Output register load (from ACC).
- halted  output  1  high while in HALT.
- state  output  STW  current state, for debug/bench.

Behaviour:
- Opcodes:
  - 0 HALT, 1 LDI, 2 LD, 3 ST, 4 ADD, 5 SUB, 6 IN, 7 OUT, 8 JMP, 9 BEQZ, A BLTZ.
  - B..F illegal: executed as NOP, which returns from DECODE to FETCH with no strobes.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Encodings 6/7 are unreachable; if entered, go to FETCH next cycle with all strobes low.
- reset high (async):
  - state := FETCH immediately.
  - All outputs forced 0 while reset is held, including halted=0 and state=0.
  - The first rising CLK edge after deassertion executes FETCH.
- Reset mid-instruction aborts it. No partial writes are issued after reset asserts.
- Outputs are Moore-style: a function of the registered state and current opcode/flags. No output registers. Strobes are valid one full cycle and are consumed at the next rising edge.
- FETCH: ir_write=1, pc_write=1, pc_src=00 -> DECODE.
- DECODE: no strobes. Next state:
  - LD/ST -> MEM
  - HALT -> HALT
  - illegal -> FETCH
  - all others -> EXEC
- EXEC:
  - LDI: acc_write, acc_src=01.
  - IN: acc_write, acc_src=11.
  - OUT: out_write.
  - ADD/SUB: alu_b_src=0, alu_op=01 or 10 -> WB. (The MDR was loaded from mem[IR[11:0]] during DECODE.)
  - JMP: pc_write, pc_src=01.
  - BEQZ: pc_write=acc_zero, pc_src=01.
  - BLTZ: pc_write=acc_neg, pc_src=01.
  - Every opcode other than ADD/SUB -> FETCH.
- MEM:
  - ST: mem_write=1 -> FETCH.
  - LD: no strobe (read latency) -> WB.
- WB:
  - LD: acc_write, acc_src=10.
  - ADD/SUB: acc_write, acc_src=00, with alu_op/alu_b_src held from EXEC.
  - -> FETCH.
- Cycle counts:
  - 3 cycles: LDI, IN, OUT, JMP, BEQZ, BLTZ, ST.
  - 4 cycles: ADD, SUB, LD.
  - 2 cycles: illegal.
- Branch flags are sampled combinationally in EXEC and reflect ACC after all prior instructions. There is no forwarding hazard because ACC writes complete before the next FETCH.
- HALT:
  - halted=1, all strobes 0.
  - Remains in HALT until reset. The opcode input is ignored.
- Unused select fields are driven 0 in every state (no X), so the bench can compare exactly.

Decomposition:
- Shared package accumulator_pkg:
  - opcode constants (OP_HALT..OP_BLTZ)
  - state encodings
  - pc_src, acc_src, alu_op encodings
  - the datapath uses the same select constants
- One natural sub-module: accumulator_decode. It is a pure combinational map (state, opcode, flags) -> control bus plus next_state. accumulator_control holds only the state register and the reset forcing.

Test Plan:
- Reset held 3 cycles, then released with opcode=1 (LDI) -> state 0,1,2,0. ir_write/pc_write=1 in cycle 1; acc_write=1 with acc_src=01 in cycle 3. All outputs 0 while reset is high.
- ADD (opcode=4) -> EXEC asserts alu_op=01, alu_b_src=0. WB asserts acc_write=1, acc_src=00. Returns to FETCH after exactly 4 cycles. The same check with SUB requires alu_op=10.
- BEQZ (opcode=9):
  - acc_zero=1 -> pc_write=1, pc_src=01 in EXEC.
  - repeated with acc_zero=0 -> pc_write=0 in EXEC.
  - BLTZ checked the same way against acc_neg.
- Full integration with accumulatorFull, running a GCD program (IN a=10, IN b=15, subtract loop) -> Output=5, halted=1, state=5, and no further strobes for 20 cycles.
- Reset asserted during WB of an ADD -> acc_write drops immediately (asynchronously), and state=0. After release, a normal FETCH follows.
- Opcode=0xC (illegal) -> FETCH, DECODE, FETCH with no acc_write, mem_write or out_write. Then opcode=0 -> HALT is held while opcode toggles randomly.

Source files
------------

// File: rtl/accumulator_pkg.sv
// Shared encodings for the accumulator control unit and its datapath.
// Opcodes, FSM states, datapath select codes and the packed control bus.
package accumulator_pkg;

    localparam int OPCODE_W = 4;
    localparam int STATE_W  = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_HALT = 4'h0,
        OP_LDI  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_IN   = 4'h6,
        OP_OUT  = 4'h7,
        OP_JMP  = 4'h8,
        OP_BEQZ = 4'h9,
        OP_BLTZ = 4'hA
    } opcode_e;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PC_INC  = 2'b00,
        PC_JUMP = 2'b01
    } pc_src_e;

    typedef enum logic [1:0] {
        ACC_ALU = 2'b00,
        ACC_IMM = 2'b01,
        ACC_MEM = 2'b10,
        ACC_IO  = 2'b11
    } acc_src_e;

    typedef enum logic [1:0] {
        ALU_PASS = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SUB  = 2'b10
    } alu_op_e;

    localparam logic ALU_B_MDR = 1'b0;
    localparam logic ALU_B_IMM = 1'b1;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       acc_write;
        logic [1:0] acc_src;
        logic [1:0] alu_op;
        logic       alu_b_src;
        logic       mem_write;
        logic       out_write;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/accumulator_decode.sv
// Combinational map (state, opcode, ACC flags) -> control bus and next state.
// Latency: zero, pure combinational.
// Backpressure: none; the datapath consumes every strobe on the next edge.
module accumulator_decode
    import accumulator_pkg::*;
(
    input  logic [STATE_W-1:0]  state,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                acc_zero,
    input  logic                acc_neg,
    output ctrl_t               ctrl,
    output logic [STATE_W-1:0]  next_state
);

    always_comb begin
        ctrl       = '0;
        next_state = S_FETCH;
        case (state)
            S_FETCH: begin
                ctrl.ir_write = 1'b1;
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_INC;
                next_state    = S_DECODE;
            end
            S_DECODE: begin
                // MDR loads mem[IR[11:0]] in the datapath during this cycle.
                case (opcode)
                    OP_LD, OP_ST: next_state = S_MEM;
                    OP_HALT:      next_state = S_HALT;
                    OP_LDI, OP_ADD, OP_SUB, OP_IN, OP_OUT,
                    OP_JMP, OP_BEQZ, OP_BLTZ: next_state = S_EXEC;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_EXEC: begin
                case (opcode)
                    OP_LDI: begin
                        ctrl.acc_write = 1'b1;
                        ctrl.acc_src   = ACC_IMM;
                    end
                    OP_IN: begin
                        ctrl.acc_write = 1'b1;
                        ctrl.acc_src   = ACC_IO;
                    end
                    OP_OUT: ctrl.out_write = 1'b1;
                    OP_ADD, OP_SUB: begin
                        ctrl.alu_b_src = ALU_B_MDR;
                        ctrl.alu_op    = (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
                        next_state     = S_WB;
                    end
                    OP_JMP: begin
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = PC_JUMP;
                    end
                    OP_BEQZ: begin
                        ctrl.pc_write = acc_zero;
                        ctrl.pc_src   = PC_JUMP;
                    end
                    OP_BLTZ: begin
                        ctrl.pc_write = acc_neg;
                        ctrl.pc_src   = PC_JUMP;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (opcode == OP_ST) begin
                    ctrl.mem_write = 1'b1;
                end else if (opcode == OP_LD) begin
                    next_state = S_WB;
                end
            end
            S_WB: begin
                case (opcode)
                    OP_LD: begin
                        ctrl.acc_write = 1'b1;
                        ctrl.acc_src   = ACC_MEM;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.acc_write = 1'b1;
                        ctrl.acc_src   = ACC_ALU;
                        ctrl.alu_b_src = ALU_B_MDR;
                        ctrl.alu_op    = (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
                    end
                    default: ;
                endcase
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
                next_state  = S_HALT;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/accumulator_control.sv
// Multicycle fetch/decode/execute sequencer driving the accumulator datapath.
// Latency: 2-4 cycles per instruction; outputs are Moore-style, unregistered.
// Backpressure: none; reset forces every output low asynchronously.
module accumulator_control
    import accumulator_pkg::*;
#(
    parameter int OPW = OPCODE_W,
    parameter int STW = STATE_W
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           acc_zero,
    input  logic           acc_neg,
    output logic           pc_write,
    output logic [1:0]     pc_src,
    output logic           ir_write,
    output logic           acc_write,
    output logic [1:0]     acc_src,
    output logic [1:0]     alu_op,
    output logic           alu_b_src,
    output logic           mem_write,
    output logic           out_write,
    output logic           halted,
    output logic [STW-1:0] state
);

    logic [STW-1:0] state_q;
    logic [STW-1:0] state_d;
    ctrl_t          ctrl;
    ctrl_t          ctrl_gated;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    accumulator_decode u_decode (
        .state      (state_q),
        .opcode     (opcode),
        .acc_zero   (acc_zero),
        .acc_neg    (acc_neg),
        .ctrl       (ctrl),
        .next_state (state_d)
    );

    // FETCH decodes to live strobes, so reset must also mask the bus itself.
    assign ctrl_gated = reset ? '0 : ctrl;

    assign pc_write  = ctrl_gated.pc_write;
    assign pc_src    = ctrl_gated.pc_src;
    assign ir_write  = ctrl_gated.ir_write;
    assign acc_write = ctrl_gated.acc_write;
    assign acc_src   = ctrl_gated.acc_src;
    assign alu_op    = ctrl_gated.alu_op;
    assign alu_b_src = ctrl_gated.alu_b_src;
    assign mem_write = ctrl_gated.mem_write;
    assign out_write = ctrl_gated.out_write;
    assign halted    = ctrl_gated.halted;
    assign state     = reset ? '0 : state_q;

endmodule
